// File: rtl/io_channel_target_if.sv
// XT I/O channel signals as seen between the chipset and an expansion target.
// The chipset drives address/strobes/write data; the target answers with data and ready.
interface io_channel_target_if;
  logic [19:0] address;
  logic        address_enable_n;
  logic        io_read_n;
  logic        io_write_n;
  logic [7:0]  data_bus_in;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_enable;
  logic        io_channel_ready;

  modport master (
    output address,
    output address_enable_n,
    output io_read_n,
    output io_write_n,
    output data_bus_in,
    input  data_bus_out,
    input  data_bus_out_enable,
    input  io_channel_ready
  );

  modport slave (
    input  address,
    input  address_enable_n,
    input  io_read_n,
    input  io_write_n,
    input  data_bus_in,
    output data_bus_out,
    output data_bus_out_enable,
    output io_channel_ready
  );
endinterface

// File: rtl/io_channel_target.sv
// XT I/O channel target: decodes a port window, stretches the cycle with
// io_channel_ready and hands each access to a local device via req/ack.
module io_channel_target #(
  parameter logic [9:0] BASE_ADDRESS = 10'h300,
  parameter int PORT_BITS = 4,
  parameter int MIN_WAIT  = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  io_channel_target_if.slave   chan,
  output logic                 local_request,
  output logic                 local_write,
  output logic [PORT_BITS-1:0] local_address,
  output logic [7:0]           local_write_data,
  input  logic [7:0]           local_read_data,
  input  logic                 local_acknowledge,
  output logic                 timeout_pulse
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    HOLD
  } state_t;

  state_t               state, state_n;
  logic                 prev_rd_n, prev_wr_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 ack_seen, ack_seen_n;
  logic [7:0]           read_reg, read_reg_n;
  logic                 req_n, write_n, tp_n;
  logic [PORT_BITS-1:0] addr_n;
  logic [7:0]           wdata_n;

  logic hit, rd_start, wr_start, start;
  logic strobe_up, ack, done, expired;

  assign hit = chan.address_enable_n &
               (chan.address[9:PORT_BITS] == BASE_ADDRESS[9:PORT_BITS]);
  assign rd_start = prev_rd_n & ~chan.io_read_n & chan.io_write_n;
  assign wr_start = prev_wr_n & ~chan.io_write_n & chan.io_read_n;
  assign start = hit & (rd_start | wr_start);

  // Abort watches the live strobe of the access in flight.
  assign strobe_up = local_write ? chan.io_write_n : chan.io_read_n;
  assign ack = local_acknowledge & local_request;
  assign done = (ack_seen | ack) & (cnt >= MIN_LAST);
  assign expired = ~ack_seen & ~ack & (cnt == CNT_MAX);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ack_seen_n = ack_seen;
    read_reg_n = read_reg;
    req_n      = local_request;
    write_n    = local_write;
    addr_n     = local_address;
    wdata_n    = local_write_data;
    tp_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          addr_n     = chan.address[PORT_BITS-1:0];
          write_n    = wr_start;
          if (wr_start) wdata_n = chan.data_bus_in;
          cnt_n      = '0;
          ack_seen_n = 1'b0;
          read_reg_n = 8'hFF;
          req_n      = 1'b1;
          state_n    = REQUEST;
        end
      end
      REQUEST: begin
        if (strobe_up) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end else begin
          if (cnt != CNT_MAX) cnt_n = cnt + CW'(1);
          if (ack) begin
            req_n      = 1'b0;
            ack_seen_n = 1'b1;
            if (!local_write) read_reg_n = local_read_data;
          end
          if (done) begin
            state_n = HOLD;
          end else if (expired) begin
            read_reg_n = 8'hFF;
            tp_n       = 1'b1;
            req_n      = 1'b0;
            state_n    = HOLD;
          end
        end
      end
      HOLD: begin
        if (prev_rd_n && prev_wr_n) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      prev_rd_n        <= 1'b1;
      prev_wr_n        <= 1'b1;
      cnt              <= '0;
      ack_seen         <= 1'b0;
      read_reg         <= 8'hFF;
      local_request    <= 1'b0;
      local_write      <= 1'b0;
      local_address    <= '0;
      local_write_data <= 8'h00;
      timeout_pulse    <= 1'b0;
    end else begin
      state            <= state_n;
      prev_rd_n        <= chan.io_read_n;
      prev_wr_n        <= chan.io_write_n;
      cnt              <= cnt_n;
      ack_seen         <= ack_seen_n;
      read_reg         <= read_reg_n;
      local_request    <= req_n;
      local_write      <= write_n;
      local_address    <= addr_n;
      local_write_data <= wdata_n;
      timeout_pulse    <= tp_n;
    end
  end

  assign chan.io_channel_ready = (state != REQUEST);
  assign chan.data_bus_out = read_reg;
  assign chan.data_bus_out_enable = (state != IDLE) & ~local_write &
                                    ~chan.io_read_n;

endmodule

// File: tb/tb_io_channel_target.sv
// Directed bench for io_channel_target: reads, writes, misses, timeout,
// abort, back-to-back accesses and mid-access reset.
module tb_io_channel_target;

  logic       clock = 1'b0;
  logic       reset;
  logic       local_request;
  logic       local_write;
  logic [3:0] local_address;
  logic [7:0] local_write_data;
  logic [7:0] local_read_data;
  logic       local_acknowledge;
  logic       timeout_pulse;

  int vectors = 0;
  int miscompares = 0;

  io_channel_target_if bus();

  io_channel_target dut (
    .clock             (clock),
    .reset             (reset),
    .chan              (bus),
    .local_request     (local_request),
    .local_write       (local_write),
    .local_address     (local_address),
    .local_write_data  (local_write_data),
    .local_read_data   (local_read_data),
    .local_acknowledge (local_acknowledge),
    .timeout_pulse     (timeout_pulse)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.io_channel_ready), 32'h1);
    chk({tag, "_dbo"}, 32'(bus.data_bus_out), 32'hFF);
    chk({tag, "_dboe"}, 32'(bus.data_bus_out_enable), 32'h0);
    chk({tag, "_req"}, 32'(local_request), 32'h0);
    chk({tag, "_lw"}, 32'(local_write), 32'h0);
    chk({tag, "_la"}, 32'(local_address), 32'h0);
    chk({tag, "_lwd"}, 32'(local_write_data), 32'h0);
    chk({tag, "_tp"}, 32'(timeout_pulse), 32'h0);
  endtask

  initial begin
    int n;
    int tp_count;
    reset = 1'b1;
    bus.address = 20'h0;
    bus.address_enable_n = 1'b1;
    bus.io_read_n = 1'b1;
    bus.io_write_n = 1'b1;
    bus.data_bus_in = 8'h00;
    local_read_data = 8'h00;
    local_acknowledge = 1'b0;
    tick();
    tick();
    chk_reset("rst");
    reset = 1'b0;
    tick();

    // Read 0x305, ack with 5A in the third REQUEST cycle
    bus.address = 20'h00305;
    bus.io_read_n = 1'b0;
    tick();
    chk("rd_ready1", 32'(bus.io_channel_ready), 32'h0);
    chk("rd_req", 32'(local_request), 32'h1);
    chk("rd_la", 32'(local_address), 32'h5);
    chk("rd_lw", 32'(local_write), 32'h0);
    chk("rd_dboe_req", 32'(bus.data_bus_out_enable), 32'h1);
    chk("rd_dbo_ff", 32'(bus.data_bus_out), 32'hFF);
    tick();
    chk("rd_ready2", 32'(bus.io_channel_ready), 32'h0);
    tick();
    chk("rd_ready3", 32'(bus.io_channel_ready), 32'h0);
    local_acknowledge = 1'b1;
    local_read_data = 8'h5A;
    tick();
    local_acknowledge = 1'b0;
    local_read_data = 8'h00;
    chk("rd_hold_ready", 32'(bus.io_channel_ready), 32'h1);
    chk("rd_hold_req", 32'(local_request), 32'h0);
    chk("rd_hold_dbo", 32'(bus.data_bus_out), 32'h5A);
    chk("rd_hold_dboe", 32'(bus.data_bus_out_enable), 32'h1);
    tick();
    chk("rd_hold_dbo2", 32'(bus.data_bus_out), 32'h5A);
    bus.io_read_n = 1'b1;
    #1;
    chk("rd_release", 32'(bus.data_bus_out_enable), 32'h0);
    tick();
    tick();

    // Write C3 to 0x30F with immediate ack
    bus.address = 20'h0030F;
    bus.data_bus_in = 8'hC3;
    bus.io_write_n = 1'b0;
    tick();
    chk("wr_ready1", 32'(bus.io_channel_ready), 32'h0);
    chk("wr_req", 32'(local_request), 32'h1);
    chk("wr_la", 32'(local_address), 32'hF);
    chk("wr_lw", 32'(local_write), 32'h1);
    chk("wr_lwd", 32'(local_write_data), 32'hC3);
    chk("wr_dboe1", 32'(bus.data_bus_out_enable), 32'h0);
    local_acknowledge = 1'b1;
    tick();
    local_acknowledge = 1'b0;
    chk("wr_ready2", 32'(bus.io_channel_ready), 32'h0);
    chk("wr_req_drop", 32'(local_request), 32'h0);
    tick();
    chk("wr_hold_ready", 32'(bus.io_channel_ready), 32'h1);
    chk("wr_dboe2", 32'(bus.data_bus_out_enable), 32'h0);
    bus.io_write_n = 1'b1;
    bus.data_bus_in = 8'h00;
    tick();
    tick();

    // Miss: address outside the window
    bus.address = 20'h00310;
    bus.io_read_n = 1'b0;
    tick();
    chk("miss_addr_req", 32'(local_request), 32'h0);
    chk("miss_addr_ready", 32'(bus.io_channel_ready), 32'h1);
    bus.io_read_n = 1'b1;
    tick();
    tick();

    // Miss: DMA owns the bus
    bus.address = 20'h00300;
    bus.address_enable_n = 1'b0;
    bus.io_read_n = 1'b0;
    tick();
    chk("miss_aen_req", 32'(local_request), 32'h0);
    chk("miss_aen_ready", 32'(bus.io_channel_ready), 32'h1);
    bus.io_read_n = 1'b1;
    bus.address_enable_n = 1'b1;
    tick();
    tick();

    // Miss: both strobes fall together
    bus.io_read_n = 1'b0;
    bus.io_write_n = 1'b0;
    tick();
    chk("miss_both_req", 32'(local_request), 32'h0);
    tick();
    chk("miss_both_ready", 32'(bus.io_channel_ready), 32'h1);
    bus.io_read_n = 1'b1;
    bus.io_write_n = 1'b1;
    tick();
    tick();

    // Timeout: read with no acknowledge
    bus.address = 20'h00302;
    bus.io_read_n = 1'b0;
    tick();
    n = 0;
    tp_count = 0;
    while (bus.io_channel_ready == 1'b0 && n < 200) begin
      n++;
      if (timeout_pulse) tp_count++;
      tick();
    end
    chk("to_low_cycles", 32'(n), 32'd64);
    chk("to_pulse_early", 32'(tp_count), 32'd0);
    chk("to_pulse", 32'(timeout_pulse), 32'h1);
    chk("to_dbo", 32'(bus.data_bus_out), 32'hFF);
    chk("to_dboe", 32'(bus.data_bus_out_enable), 32'h1);
    chk("to_req", 32'(local_request), 32'h0);
    tick();
    chk("to_pulse_end", 32'(timeout_pulse), 32'h0);
    bus.io_read_n = 1'b1;
    tick();
    tick();

    // Abort: strobe rises in REQUEST, late ack ignored
    bus.address = 20'h00301;
    bus.io_read_n = 1'b0;
    tick();
    chk("ab_req", 32'(local_request), 32'h1);
    bus.io_read_n = 1'b1;
    tick();
    chk("ab_ready", 32'(bus.io_channel_ready), 32'h1);
    chk("ab_req_drop", 32'(local_request), 32'h0);
    chk("ab_dboe", 32'(bus.data_bus_out_enable), 32'h0);
    tick();
    local_acknowledge = 1'b1;
    local_read_data = 8'h77;
    tick();
    local_acknowledge = 1'b0;
    local_read_data = 8'h00;
    chk("ab_late_req", 32'(local_request), 32'h0);
    chk("ab_late_ready", 32'(bus.io_channel_ready), 32'h1);
    chk("ab_late_dbo", 32'(bus.data_bus_out), 32'hFF);
    tick();

    // Back-to-back reads
    bus.address = 20'h00304;
    bus.io_read_n = 1'b0;
    tick();
    chk("b1_req", 32'(local_request), 32'h1);
    local_acknowledge = 1'b1;
    local_read_data = 8'h11;
    tick();
    local_acknowledge = 1'b0;
    tick();
    chk("b1_dbo", 32'(bus.data_bus_out), 32'h11);
    chk("b1_ready", 32'(bus.io_channel_ready), 32'h1);
    bus.io_read_n = 1'b1;
    tick();
    tick();
    bus.address = 20'h00306;
    bus.io_read_n = 1'b0;
    tick();
    chk("b2_req", 32'(local_request), 32'h1);
    chk("b2_la", 32'(local_address), 32'h6);
    chk("b2_dbo_ff", 32'(bus.data_bus_out), 32'hFF);
    local_acknowledge = 1'b1;
    local_read_data = 8'h22;
    tick();
    local_acknowledge = 1'b0;
    tick();
    chk("b2_dbo", 32'(bus.data_bus_out), 32'h22);
    bus.io_read_n = 1'b1;
    tick();
    tick();

    // Reset in the middle of a write REQUEST
    bus.address = 20'h0030A;
    bus.data_bus_in = 8'h05;
    bus.io_write_n = 1'b0;
    tick();
    chk("mr_req", 32'(local_request), 32'h1);
    reset = 1'b1;
    tick();
    chk_reset("mr");
    bus.io_write_n = 1'b1;
    reset = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/io_channel_target.md
# io_channel_target

- Bus-side responder for the XT I/O channel: the target end of the cycles the chipset issues on `io_read_n`/`io_write_n`.
- Decodes a port window and stretches the channel cycle through `io_channel_ready`.
- Hands each access to a local device over a request/acknowledge handshake, then returns read data on the channel data bus.
- Sits on expansion-side logic (option ROM/peripheral cards) facing the chipset's address, data and strobe outputs.

## Interface

Parameters:
- `BASE_ADDRESS`, 10'h300: I/O window base; the bits below `PORT_BITS` must be zero.
- `PORT_BITS`, 4: window size is 2^PORT_BITS ports.
- `MIN_WAIT`, 2: minimum cycles `io_channel_ready` is held low per access (≥1).
- `TIMEOUT`, 64: cycles without local acknowledge before forced completion (> MIN_WAIT).

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `address`, in, 20: channel address; only bits [9:0] are decoded.
- `address_enable_n`, in, 1: low means a DMA cycle owns the bus, so no decode.
- `io_read_n`, `io_write_n`, in, 1 each: channel I/O strobes, active low.
- `data_bus_in`, in, 8: channel data for writes.
- `data_bus_out`, out, 8: read data to the channel.
- `data_bus_out_enable`, out, 1: high while the target drives the data bus.
- `io_channel_ready`, out, 1: low inserts wait states.
- `local_request`, out, 1: access pending to the local device.
- `local_write`, out, 1: 1 = write, 0 = read; valid with `local_request`.
- `local_address`, out, PORT_BITS: port offset within the window.
- `local_write_data`, out, 8: latched write data.
- `local_read_data`, in, 8: sampled on acknowledge for reads.
- `local_acknowledge`, in, 1: single-cycle completion from the local device.
- `timeout_pulse`, out, 1: one-cycle pulse on forced completion.

## Operation

- Strobes are registered each cycle (`prev_rd_n`, `prev_wr_n`).
- Start condition, all of:
  - a falling edge on exactly one strobe (registered 1, current 0);
  - the other strobe is high;
  - `address_enable_n`=1;
  - `address[9:PORT_BITS]` == `BASE_ADDRESS[9:PORT_BITS]`.
- Both strobes low together is never a start.
- IDLE:
  - On a start, latch `local_address` = `address[PORT_BITS-1:0]`, `local_write`, and for writes `local_write_data` = `data_bus_in`.
  - Clear the wait counter and go to REQUEST.
- REQUEST:
  - `local_request`=1 and `io_channel_ready`=0; the wait counter increments each cycle, saturating.
  - `local_acknowledge`=1: latch `local_read_data` into the read register (reads only), drop `local_request` and set `ack_seen`.
  - Leave for HOLD when `ack_seen` (or ack this cycle) and counter ≥ MIN_WAIT-1.
  - Counter reaches TIMEOUT-1 without ack: read register = 8'hFF, pulse `timeout_pulse`, drop `local_request`, go to HOLD.
  - Active strobe rises before HOLD (abort): drop `local_request` and go to IDLE. A late `local_acknowledge` is then ignored.
- HOLD:
  - `io_channel_ready`=1.
  - Return to IDLE when both registered strobes are high.
  - A new falling edge is accepted only from IDLE.
- `data_bus_out` = read register.
- `data_bus_out_enable` = (state REQUEST or HOLD) & ~`local_write` & ~`io_read_n`. It is combinational on the strobe, so it releases in the same cycle the strobe rises.
- The read register is loaded with 8'hFF at every start, so the bus shows FF until data is valid.

## Timing

- Reset values:
  - IDLE; `io_channel_ready`=1.
  - `data_bus_out`=8'hFF; `data_bus_out_enable`=0.
  - `local_request`=0, `local_write`=0, `local_address`=0, `local_write_data`=0.
  - `timeout_pulse`=0.
- Reset mid-access returns to IDLE with these values on the next edge, regardless of strobes.
- Strobe falls before edge N → registered start at edge N → REQUEST from edge N.
  - `io_channel_ready` is low and `local_request` is high during cycle N+1, i.e. 1 cycle after the strobe is sampled low.
- `local_acknowledge` sampled at edge M with MIN_WAIT satisfied → HOLD at M+1.
  - `io_channel_ready` is high and read data is valid in the cycle after M.
- Minimum low time of `io_channel_ready` is MIN_WAIT cycles, even for an immediate ack.
- Timeout: `io_channel_ready` is low for exactly TIMEOUT cycles, then high. `timeout_pulse` is high in the first HOLD cycle.
- `local_request` deasserts the cycle after ack, timeout or abort; it never spans two accesses.

## Test plan

- Read, BASE=0x300, ack with data 8'h5A in the 3rd REQUEST cycle:
  - `address`=0x305, `io_read_n` low → `local_address`=5, `local_write`=0;
  - `io_channel_ready` low 3 cycles; `data_bus_out`=8'h5A with `data_bus_out_enable`=1 until `io_read_n` rises.
- Write 8'hC3 to 0x30F, immediate ack, MIN_WAIT=2:
  - `local_write_data`=8'hC3, `local_address`=4'hF;
  - `io_channel_ready` low exactly 2 cycles; `data_bus_out_enable` stays 0.
- Non-hits:
  - `address`=0x310, or `address_enable_n`=0, or both strobes low → no `local_request`, `io_channel_ready` stays 1.
- No ack, TIMEOUT=64 → `io_channel_ready` low 64 cycles, one `timeout_pulse`, read returns 8'hFF.
- Abort:
  - `io_read_n` rises in REQUEST → IDLE next cycle, `io_channel_ready`=1;
  - an ack two cycles later changes nothing.
- Back-to-back: two reads with one idle cycle between strobes → two separate requests. Reset asserted mid-REQUEST → all outputs at reset values next cycle.
